// File: rtl/main_ctrl.sv
// Multi-cycle main control FSM: accepts one instruction per trip through IDLE
// and sequences DECODE/EXEC/MEM/WB strobes for R-type, LW, SW and BEQ.
module main_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       instr_valid,
   input  logic [7:0] instr,
   input  logic       zero,
   output logic       instr_ready,
   output logic [1:0] aluop,
   output logic [3:0] funct,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       pc_write,
   output logic       branch_take,
   output logic       illegal,
   output logic [7:0] retired
);

   typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

   state_t     state;
   logic [7:0] ir;

   logic [3:0] op;
   logic       is_r, is_lw, is_sw, is_beq, funct_ok, legal, active;

   assign op       = ir[7:4];
   assign is_r     = (op == 4'b0000);
   assign is_lw    = (op == 4'b0001);
   assign is_sw    = (op == 4'b0010);
   assign is_beq   = (op == 4'b0011);
   assign funct_ok = ir[3:0] inside {4'b0000, 4'b0110, 4'b0111, 4'b1000, 4'b1110, 4'b1111};
   assign legal    = (is_r && funct_ok) || is_lw || is_sw || is_beq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ir      <= '0;
         retired <= '0;
      end else begin
         if (pc_write) retired <= retired + 8'd1;
         case (state)
            IDLE:    if (instr_valid) begin
                        ir    <= instr;
                        state <= DECODE;
                     end
            DECODE:  state <= legal ? EXEC : IDLE;
            EXEC:    state <= is_r ? WB : (is_beq ? IDLE : MEM);
            MEM:     state <= is_lw ? WB : IDLE;
            WB:      state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Everything below depends only on state and IR, except branch_take.
   assign active      = (state == EXEC) || (state == MEM) || (state == WB);
   assign instr_ready = (state == IDLE);
   assign aluop       = !active ? 2'b00 : (is_r ? 2'b10 : (is_beq ? 2'b01 : 2'b00));
   assign funct       = (active && is_r) ? ir[3:0] : 4'b0000;
   assign mem_read    = (state == MEM) && is_lw;
   assign mem_write   = (state == MEM) && is_sw;
   assign reg_write   = (state == WB);
   assign mem_to_reg  = (state == WB) && is_lw;
   assign pc_write    = (state == WB) || ((state == MEM) && is_sw) || ((state == EXEC) && is_beq);
   assign branch_take = (state == EXEC) && is_beq && zero;
   assign illegal     = (state == DECODE) && !legal;

endmodule

// File: tb/tb_main_ctrl.sv
// Randomized bench for main_ctrl: per-instruction phase model, retired counter
// model, async reset mid-instruction.
module tb_main_ctrl;
   logic       clk = 1'b0;
   logic       rst_n, instr_valid, zero;
   logic [7:0] instr;
   logic       instr_ready, mem_read, mem_write, reg_write, mem_to_reg;
   logic       pc_write, branch_take, illegal;
   logic [1:0] aluop;
   logic [3:0] funct;
   logic [7:0] retired;

   int         n_err = 0;
   int         n_chk = 0;
   logic [7:0] exp_ret = 8'd0;

   localparam logic [13:0] IDLE_V = 14'b1_00_0000_0000000;

   main_ctrl dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .zero(zero),
      .instr_ready(instr_ready), .aluop(aluop), .funct(funct), .mem_read(mem_read),
      .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .pc_write(pc_write), .branch_take(branch_take), .illegal(illegal), .retired(retired)
   );

   always #5 clk = ~clk;

   logic [13:0] obs;
   assign obs = {instr_ready, aluop, funct, mem_read, mem_write, reg_write,
                 mem_to_reg, pc_write, branch_take, illegal};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_legal(input logic [7:0] i);
      case (i[7:4])
         4'd0:       return i[3:0] inside {4'd0, 4'd6, 4'd7, 4'd8, 4'd14, 4'd15};
         4'd1, 4'd2, 4'd3: return 1'b1;
         default:    return 1'b0;
      endcase
   endfunction

   // Cycles spent outside IDLE after the accept edge (spec latency minus one).
   function automatic int busy_cycles(input logic [7:0] i);
      if (!is_legal(i)) return 1;
      case (i[7:4])
         4'd0:    return 3;
         4'd1:    return 4;
         4'd2:    return 3;
         default: return 2;
      endcase
   endfunction

   // Phase letter of busy cycle k: D, E, then M and/or W depending on class.
   function automatic byte phase(input logic [7:0] i, input int k);
      if (k == 1) return "D";
      if (k == 2) return "E";
      if (k == 3) return (i[7:4] == 4'd0) ? "W" : "M";
      return "W";
   endfunction

   function automatic logic [13:0] expv(input logic [7:0] i, input int k, input logic z);
      byte        p    = phase(i, k);
      logic [3:0] o    = i[7:4];
      bit         lg   = is_legal(i);
      bit         post = (p != "D");
      logic [1:0] a    = 2'b00;
      logic [3:0] f    = 4'b0000;
      if (post) begin
         a = (o == 4'd0) ? 2'b10 : (o == 4'd3) ? 2'b01 : 2'b00;
         f = (o == 4'd0) ? i[3:0] : 4'b0000;
      end
      return {1'b0, a, f,
              1'(p == "M" && o == 4'd1),
              1'(p == "M" && o == 4'd2),
              1'(p == "W"),
              1'(p == "W" && o == 4'd1),
              1'(lg && k == busy_cycles(i)),
              1'(p == "E" && o == 4'd3 && z),
              1'(p == "D" && !lg)};
   endfunction

   // Starts just after a rising edge with the DUT idle; ends just after the
   // edge that returns it to IDLE. zs: 0/1 forces zero, 2 randomizes it.
   task automatic run_instr(input logic [7:0] i, input int zs);
      logic [13:0] e;
      #1 instr_valid = 1'b1; instr = i; zero = 1'($urandom);
      @(negedge clk);
      chk($sformatf("idle_%02h", i), obs, IDLE_V);
      chk("ret_idle", retired, exp_ret);
      @(posedge clk);
      for (int k = 1; k <= busy_cycles(i); k++) begin
         #1 instr_valid = 1'($urandom); instr = 8'($urandom);
         zero = (zs == 2) ? 1'($urandom) : 1'(zs);
         @(negedge clk);
         e = expv(i, k, zero);
         chk($sformatf("out_%02h_c%0d", i, k), obs, e);
         chk("ret_busy", retired, exp_ret);
         @(posedge clk);
         if (e[2]) exp_ret++;
      end
   endtask

   task automatic idle_cyc();
      #1 instr_valid = 1'b0; instr = 8'($urandom);
      @(negedge clk);
      chk("idle_novalid", obs, IDLE_V);
      @(posedge clk);
   endtask

   task automatic lw_reset_in_mem();
      logic [13:0] e;
      #1 instr_valid = 1'b1; instr = 8'h10;
      @(negedge clk);
      chk("lw_idle", obs, IDLE_V);
      @(posedge clk);
      for (int k = 1; k <= 3; k++) begin
         #1 instr_valid = 1'($urandom); instr = 8'($urandom);
         @(negedge clk);
         e = expv(8'h10, k, zero);
         chk($sformatf("lwr_c%0d", k), obs, e);
         if (k < 3) @(posedge clk);
      end
      #2 rst_n = 1'b0;
      exp_ret = 8'd0;
      #1 chk("rst_async_out", obs, IDLE_V);
      chk("rst_async_ret", retired, exp_ret);
      @(posedge clk);
      #1 chk("rst_hold_out", obs, IDLE_V);
      chk("rst_hold_ret", retired, exp_ret);
      #1 rst_n = 1'b1;
   endtask

   logic [3:0] rfun [6] = '{4'd0, 4'd6, 4'd7, 4'd8, 4'd14, 4'd15};

   initial begin
      logic [7:0] ri;
      int         sel;
      rst_n = 1'b0; instr_valid = 1'b0; instr = 8'h00; zero = 1'b0;
      #3 chk("reset_out", obs, IDLE_V);
      chk("reset_ret", retired, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      run_instr(8'h07, 2);
      run_instr(8'h10, 2);
      run_instr(8'h30, 1);
      run_instr(8'h30, 0);
      run_instr(8'h0A, 2);
      run_instr(8'h50, 2);
      idle_cyc();
      run_instr(8'h20, 2);

      for (int n = 0; n < 400; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 6)       ri = {4'd0, rfun[sel]};
         else if (sel == 6) ri = {4'd1, 4'($urandom)};
         else if (sel == 7) ri = {4'd2, 4'($urandom)};
         else if (sel == 8) ri = {4'd3, 4'($urandom)};
         else               ri = 8'($urandom);
         run_instr(ri, 2);
         if ($urandom_range(0, 7) == 0) idle_cyc();
      end

      lw_reset_in_mem();
      run_instr(8'h0F, 2);
      run_instr(8'h20, 2);
      run_instr(8'h30, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/main_ctrl.md
MAIN_CTRL -- requirements
Module: main_ctrl

Interface
- REQ-001: The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
- REQ-002: The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-003: The block SHALL have port instr_valid, input, 1 bit: the upstream instruction source has an instruction.
- REQ-004: The block SHALL have port instr, input, 8 bits: instr[7:4] is the main opcode and instr[3:0] is funct.
- REQ-005: The block SHALL have port zero, input, 1 bit: ALU zero flag, sampled only in EXEC for BEQ.
- REQ-006: The block SHALL have port instr_ready, output, 1 bit: high exactly when the state is IDLE.
- REQ-007: The block SHALL have port aluop, output, 2 bits: drives the ALU control unit's a1 (bit 1) and a0 (bit 0).
- REQ-008: The block SHALL have port funct, output, 4 bits: drives the ALU control unit's op3..op0.
- REQ-009: The block SHALL have ports mem_read, mem_write, reg_write, mem_to_reg, pc_write and branch_take, each an output of 1 bit: datapath strobes.
- REQ-010: The block SHALL have port illegal, output, 1 bit: a one-cycle pulse when an instruction is rejected.
- REQ-011: The block SHALL have port retired, output, 8 bits: the count of completed legal instructions.

Function
- REQ-012: Main opcode encoding SHALL be: 0000 = R-type; 0001 = LW; 0010 = SW; 0011 = BEQ; all other values are illegal.
- REQ-013: The legal R-type funct values SHALL be 0000 ADD, 0110 OR, 0111 AND, 1000 SUB, 1110 NAND and 1111 NOR; any other funct makes the instruction illegal.
- REQ-014: The FSM SHALL have exactly the states IDLE, DECODE, EXEC, MEM and WB.
- REQ-015: Handshake: when IDLE and instr_valid=1 on a clock edge, instr SHALL be latched into an internal 8-bit IR and the state SHALL move to DECODE; when instr_valid=0 the state SHALL remain IDLE.
- REQ-016: instr SHALL be ignored in every state other than IDLE.
- REQ-017: Transitions out of DECODE: illegal opcode or funct -> IDLE with illegal=1 for that cycle; otherwise -> EXEC.
- REQ-018: Transitions out of EXEC: R-type -> WB; LW or SW -> MEM; BEQ -> IDLE.
- REQ-019: Transitions out of MEM: LW -> WB; SW -> IDLE.
- REQ-020: Transitions out of WB: always -> IDLE.
- REQ-021: In EXEC, aluop SHALL be 10 for R-type, 00 for LW/SW and 01 for BEQ.
- REQ-022: In EXEC, funct SHALL equal IR[3:0] for R-type and 0000 otherwise.
- REQ-023: In MEM and WB, aluop and funct SHALL hold their EXEC values.
- REQ-024: In IDLE and DECODE, aluop and funct SHALL be 00 and 0000.
- REQ-025: mem_read SHALL be 1 only in MEM for LW.
- REQ-026: mem_write SHALL be 1 only in MEM for SW.
- REQ-027: reg_write SHALL be 1 only in WB.
- REQ-028: mem_to_reg SHALL be 1 only in WB for LW.
- REQ-029: branch_take SHALL equal zero when in EXEC for BEQ, and 0 otherwise; this is the only output with a combinational path from an input.
- REQ-030: pc_write SHALL be 1 for one cycle on the final state of each legal instruction: WB for R-type and LW, MEM for SW, EXEC for BEQ.
- REQ-031: retired SHALL increment by 1 on the clock edge that ends each cycle where pc_write=1, and SHALL wrap from 255 to 0.
- REQ-032: Illegal instructions SHALL NOT increment retired and SHALL NOT assert any strobe.
- REQ-033: Latency from the accept edge back to IDLE SHALL be 4 cycles for R-type, 5 for LW, 4 for SW, 3 for BEQ and 2 for an illegal instruction.
- REQ-034: All outputs other than instr_ready and branch_take SHALL be decoded from registered state and IR only.

Reset
- REQ-035: While rst_n=0 the block SHALL immediately force state=IDLE, IR=00000000 and retired=0, and every strobe, aluop, funct and illegal to 0; instr_ready SHALL be 1.
- REQ-036: Reset asserted mid-instruction SHALL abort that instruction without incrementing retired.
- REQ-037: After rst_n rises, the first accept SHALL be possible on the first rising clk edge.

Verification
- REQ-038: Accept instr=00000111 (AND) -> EXEC: aluop=10, funct=0111; WB: reg_write=1, pc_write=1; retired=1; back in IDLE 4 cycles after accept.
- REQ-039: Accept 00010000 (LW) -> EXEC aluop=00, funct=0000; MEM mem_read=1; WB reg_write=1, mem_to_reg=1; 5 cycles total.
- REQ-040: BEQ (00110000) twice, once with zero=1 and once with zero=0 -> EXEC aluop=01; branch_take=1 only in the zero=1 case; pc_write=1 in both; retired +2.
- REQ-041: Accept 00001010 (bad funct), then 01010000 (bad opcode) -> illegal pulse in DECODE for each, no strobes, retired unchanged, IDLE after 2 cycles each.
- REQ-042: Hold instr_valid=1 and change instr during EXEC of an SW -> the change is ignored, mem_write=1 in MEM, and the next accept occurs only in IDLE.
- REQ-043: Retire 256 instructions, then drop rst_n during MEM of a LW -> retired wraps to 0; the async reset clears all outputs before the next clk edge and retired stays 0.
